centroid_div_ctrl: RTL and testbench

CENTROID_DIV_CTRL -- requirements
Module: centroid_div_ctrl

---
 rtl/centroid_pkg.sv | 16 +
 rtl/centroid_div_ctrl_if.sv | 31 +++
 rtl/seq_divider.sv | 55 +++++
 rtl/centroid_div_ctrl.sv | 134 +++++++++++++
 tb/tb_centroid_div_ctrl.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/centroid_pkg.sv
// Shared defaults and FSM state encoding for the centroid divider block.
package centroid_pkg;

    localparam int DEF_SUM_S_WIDTH  = 20;
    localparam int DEF_SUM_XY_WIDTH = 28;
    localparam int DEF_Q_WIDTH      = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DIV_X = 3'd2,
        DIV_Y = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/centroid_div_ctrl_if.sv
// Job handshake and result bus of the centroid divider.
interface centroid_div_ctrl_if
    import centroid_pkg::*;
#(
    parameter int SUM_S_WIDTH  = DEF_SUM_S_WIDTH,
    parameter int SUM_XY_WIDTH = DEF_SUM_XY_WIDTH,
    parameter int Q_WIDTH      = DEF_Q_WIDTH
);

    logic                    iSTART;
    logic [SUM_S_WIDTH-1:0]  iSUM_S;
    logic [SUM_XY_WIDTH-1:0] iSUM_SX;
    logic [SUM_XY_WIDTH-1:0] iSUM_SY;
    logic                    oBUSY;
    logic                    oDONE;
    logic                    oVALID;
    logic [Q_WIDTH-1:0]      oCX;
    logic [Q_WIDTH-1:0]      oCY;
    logic                    oDIV0;

    modport master (
        output iSTART, iSUM_S, iSUM_SX, iSUM_SY,
        input  oBUSY, oDONE, oVALID, oCX, oCY, oDIV0
    );

    modport slave (
        input  iSTART, iSUM_S, iSUM_SX, iSUM_SY,
        output oBUSY, oDONE, oVALID, oCX, oCY, oDIV0
    );

endinterface

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per load/step cycle.
module seq_divider #(
    parameter int DW = 28,
    parameter int SW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [DW-1:0] dividend,
    input  logic [SW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic          last,
    output logic          full
);

    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] LAST_C = CW'(DW - 1);
    localparam logic [CW-1:0] FULL_C = CW'(DW);

    logic [SW-1:0] rem_q;
    logic [SW-1:0] rem_src;
    logic [SW-1:0] rem_nx;
    logic [SW:0]   rem_sh;
    logic [DW-1:0] quo_q;
    logic [DW-1:0] quo_src;
    logic          fits;
    logic [CW-1:0] cnt;

    // Load restarts from a clean remainder and performs the first step at once.
    always_comb begin
        rem_src = load ? '0 : rem_q;
        quo_src = load ? dividend : quo_q;
        rem_sh  = {rem_src, quo_src[DW-1]};
        fits    = rem_sh >= {1'b0, divisor};
        rem_nx  = fits ? SW'(rem_sh - {1'b0, divisor}) : rem_sh[SW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt   <= '0;
        end else if (load || step) begin
            rem_q <= rem_nx;
            quo_q <= {quo_src[DW-2:0], fits};
            cnt   <= load ? CW'(1) : cnt + CW'(1);
        end
    end

    assign quotient = quo_q;
    assign last     = (cnt == LAST_C);
    assign full     = (cnt == FULL_C);

endmodule

// File: rtl/centroid_div_ctrl.sv
// Centroid divider: SX/S and SY/S on one shared divider.
// CENTROID_ROUND_EN selects round-to-nearest quotients.
module centroid_div_ctrl
    import centroid_pkg::*;
#(
    parameter int SUM_S_WIDTH  = DEF_SUM_S_WIDTH,
    parameter int SUM_XY_WIDTH = DEF_SUM_XY_WIDTH,
    parameter int Q_WIDTH      = DEF_Q_WIDTH
) (
    input logic                CCLK,
    input logic                RST,
    centroid_div_ctrl_if.slave bus
);

`ifdef CENTROID_ROUND_EN
    localparam int DW = SUM_XY_WIDTH + 1;
`else
    localparam int DW = SUM_XY_WIDTH;
`endif

    state_t                  state;
    logic [SUM_S_WIDTH-1:0]  sum_s;
    logic [SUM_XY_WIDTH-1:0] sum_sx;
    logic [SUM_XY_WIDTH-1:0] sum_sy;
    logic [DW-1:0]           x_ext;
    logic [DW-1:0]           y_ext;
    logic [DW-1:0]           dividend;
    logic [DW-1:0]           quotient;
    logic [Q_WIDTH-1:0]      qx;
    logic [Q_WIDTH-1:0]      cx;
    logic [Q_WIDTH-1:0]      cy;
    logic                    div_load;
    logic                    div_step;
    logic                    div_last;
    logic                    div_full;
    logic                    busy;
    logic                    done;
    logic                    valid;
    logic                    div0;

    function automatic logic [Q_WIDTH-1:0] sat(input logic [DW-1:0] q);
        return (|q[DW-1:Q_WIDTH]) ? {Q_WIDTH{1'b1}} : q[Q_WIDTH-1:0];
    endfunction

`ifdef CENTROID_ROUND_EN
    assign x_ext = {1'b0, sum_sx} + DW'(sum_s >> 1);
    assign y_ext = {1'b0, sum_sy} + DW'(sum_s >> 1);
`else
    assign x_ext = sum_sx;
    assign y_ext = sum_sy;
`endif

    // X starts in LOAD; Y is loaded while X's quotient is still readable.
    always_comb begin
        dividend = (state == DIV_Y) ? y_ext : x_ext;
        div_load = ((state == LOAD) && (sum_s != '0))
                 || ((state == DIV_Y) && div_full);
        div_step = (state == DIV_X)
                 || ((state == DIV_Y) && !div_full);
    end

    seq_divider #(
        .DW(DW),
        .SW(SUM_S_WIDTH)
    ) u_div (
        .clk     (CCLK),
        .rst     (RST),
        .load    (div_load),
        .step    (div_step),
        .dividend(dividend),
        .divisor (sum_s),
        .quotient(quotient),
        .last    (div_last),
        .full    (div_full)
    );

    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            sum_s  <= '0;
            sum_sx <= '0;
            sum_sy <= '0;
            qx     <= '0;
            cx     <= '0;
            cy     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            valid  <= 1'b0;
            div0   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.iSTART) begin
                        state  <= LOAD;
                        sum_s  <= bus.iSUM_S;
                        sum_sx <= bus.iSUM_SX;
                        sum_sy <= bus.iSUM_SY;
                        valid  <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= (sum_s == '0) ? DONE : DIV_X;
                end
                DIV_X: begin
                    if (div_last) state <= DIV_Y;
                end
                DIV_Y: begin
                    if (div_full) qx <= sat(quotient);
                    else if (div_last) state <= DONE;
                end
                DONE: begin
                    cx    <= (sum_s == '0) ? '0 : qx;
                    cy    <= (sum_s == '0) ? '0 : sat(quotient);
                    div0  <= (sum_s == '0);
                    done  <= 1'b1;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.oBUSY  = busy;
    assign bus.oDONE  = done;
    assign bus.oVALID = valid;
    assign bus.oCX    = cx;
    assign bus.oCY    = cy;
    assign bus.oDIV0  = div0;

endmodule

// File: tb/tb_centroid_div_ctrl.sv
// Randomised bench for centroid_div_ctrl against an arithmetic model.
module tb_centroid_div_ctrl;

`ifdef CENTROID_ROUND_EN
    localparam bit ROUND = 1'b1;
    localparam int DW = 29;
`else
    localparam bit ROUND = 1'b0;
    localparam int DW = 28;
`endif
    localparam int LAT = 1 + 2 * DW;
    localparam longint QMAX = 1023;
    localparam longint XYMAX = (64'd1 << 28) - 1;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    centroid_div_ctrl_if bus ();

    centroid_div_ctrl dut (
        .CCLK(clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model_q(input longint sum, input longint s);
        longint q;
        if (s == 0) return 0;
        q = ROUND ? (sum + s / 2) / s : sum / s;
        return (q > QMAX) ? QMAX : q;
    endfunction

    task automatic run_job(input string tag, input longint s, input longint sx,
                           input longint sy, input int poke_at);
        longint pcx, pcy, pdiv0;
        int n, busy_drop, held_bad;
        pcx = bus.oCX;
        pcy = bus.oCY;
        pdiv0 = bus.oDIV0;
        busy_drop = 0;
        held_bad = 0;
        @(negedge clk);
        bus.iSTART = 1'b1;
        bus.iSUM_S = 20'(s);
        bus.iSUM_SX = 28'(sx);
        bus.iSUM_SY = 28'(sy);
        @(posedge clk);
        #1;
        bus.iSTART = 1'b0;
        check({tag, "_valid_drop"}, bus.oVALID, 0);
        n = 0;
        while (n <= 300) begin
            if (bus.oDONE) break;
            if (!bus.oBUSY) busy_drop++;
            if (bus.oCX != pcx || bus.oCY != pcy || bus.oDIV0 != pdiv0) held_bad++;
            if (n == poke_at) begin
                bus.iSTART = 1'b1;
                bus.iSUM_S = 20'd7;
                bus.iSUM_SX = 28'd70;
                bus.iSUM_SY = 28'd700;
            end else begin
                bus.iSTART = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.iSTART = 1'b0;
        check({tag, "_latency"}, n, (s == 0) ? 2 : LAT);
        check({tag, "_busy"}, busy_drop, 0);
        check({tag, "_held"}, held_bad, 0);
        check({tag, "_cx"}, bus.oCX, model_q(sx, s));
        check({tag, "_cy"}, bus.oCY, model_q(sy, s));
        check({tag, "_div0"}, bus.oDIV0, (s == 0) ? 1 : 0);
        check({tag, "_valid"}, bus.oVALID, 1);
        @(posedge clk);
        #1;
        check({tag, "_idle_after"}, {bus.oDONE, bus.oBUSY}, 0);
    endtask

    initial begin
        int dones;
        longint s, sx, sy, q;
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.iSTART = 1'b0;
        bus.iSUM_S = '0;
        bus.iSUM_SX = '0;
        bus.iSUM_SY = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.oBUSY, 0);
        check("rst_done", bus.oDONE, 0);
        check("rst_valid", bus.oVALID, 0);
        check("rst_div0", bus.oDIV0, 0);
        check("rst_cx", bus.oCX, 0);
        check("rst_cy", bus.oCY, 0);
        @(negedge clk);
        rst = 1'b0;

        run_job("basic", 100, 32000, 24000, -1);
        run_job("div0", 0, 500, 700, -1);
        run_job("sat", 1, 5000, 100, -1);
        run_job("restart_ignored", 100, 32000, 24000, 10);
        run_job("start_in_done", 4, 40, 80, LAT - 1);
        run_job("round", 3, 5, 4, -1);

        // Reset in the middle of the Y division.
        run_job("pre_rst", 9, 900, 1800, -1);
        @(negedge clk);
        bus.iSTART = 1'b1;
        bus.iSUM_S = 20'd50;
        bus.iSUM_SX = 28'd5000;
        bus.iSUM_SY = 28'd2500;
        @(posedge clk);
        #1;
        bus.iSTART = 1'b0;
        repeat (DW + 10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_outputs",
              {bus.oBUSY, bus.oDONE, bus.oVALID, bus.oDIV0, bus.oCX, bus.oCY}, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (bus.oDONE) dones++;
        end
        check("rst_mid_no_done", dones, 0);
        run_job("after_rst", 4, 8, 12, -1);

        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 5))
                0: s = 0;
                1: s = $urandom_range(2000, 1048575);
                default: s = $urandom_range(1, 2000);
            endcase
            if (s == 0 || s > 2000) begin
                sx = longint'($urandom) & XYMAX;
                sy = longint'($urandom) & XYMAX;
            end else begin
                q = $urandom_range(0, 1100);
                sx = s * q + longint'($urandom % 32'(s));
                q = $urandom_range(0, 1100);
                sy = s * q + longint'($urandom % 32'(s));
            end
            run_job("rand", s, sx, sy, (i % 3 == 0) ? int'($urandom_range(0, LAT)) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
